data_memory_hs: RTL and testbench

//   Y86-64 data memory with a valid/ready handshake, configurable access latency and

---
 rtl/data_memory_hs.sv | 142 ++++++++++++++
 tb/tb_data_memory_hs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// data_memory_hs
//   Y86-64 data memory for the memory stage, with a valid/ready handshake on
//   both the request and the response side, a programmable access latency and
//   a full-width address range check that produces the SADR error flag.
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     req_valid / req_ready       request handshake (ready only in IDLE)
//     icode, valA, valE, valP     instruction fields, captured at accept
//     resp_valid / resp_ready     response handshake
//     valM                        read data (0 for writes, no-ops, errors)
//     mem_error                   address out of range on a memory icode
//     ram_val                     debug: word at the accessed address after the access
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   BUSY  | latency countdown; access performed on the edge where cnt == 0
//   RESP  | response presented, held until resp_ready
module data_memory_hs #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] valM,
    output logic              mem_error,
    output logic [DATA_W-1:0] ram_val
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

    state_t state, state_nxt;

    op_t               op, op_dec;
    logic [DATA_W-1:0] addr, addr_dec;
    logic [DATA_W-1:0] wdata, wdata_dec;
    logic [3:0]        cnt;
    logic              in_range;
    logic              commit;
    logic [ADDR_W-1:0] word_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    // Access decode. Anything not listed (including X) becomes a no-op.
    always_comb begin
        op_dec    = OP_NONE;
        addr_dec  = valE;
        wdata_dec = valA;
        case (icode)
            4'h5:        op_dec = OP_READ;
            4'h4, 4'hA:  op_dec = OP_WRITE;
            4'h8: begin
                op_dec    = OP_WRITE;
                wdata_dec = valP;
            end
            4'h9, 4'hB: begin
                op_dec   = OP_READ;
                addr_dec = valA;
            end
            default:     op_dec = OP_NONE;
        endcase
    end

    // The whole 64-bit address is range checked; upper bits are never dropped.
    assign in_range  = ((addr >> ADDR_W) == '0);
    assign word_addr = addr[ADDR_W-1:0];
    assign commit    = (state == BUSY) && (cnt == 4'd0);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)  state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            op        <= OP_NONE;
            addr      <= '0;
            wdata     <= '0;
            valM      <= '0;
            mem_error <= 1'b0;
            ram_val   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op    <= op_dec;
                addr  <= addr_dec;
                wdata <= wdata_dec;
                cnt   <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                valM      <= '0;
                mem_error <= 1'b0;
                ram_val   <= '0;
                if (op != OP_NONE) begin
                    if (!in_range) begin
                        mem_error <= 1'b1;
                    end else if (op == OP_READ) begin
                        valM    <= mem[word_addr];
                        ram_val <= mem[word_addr];
                    end else begin
                        ram_val <= wdata;
                    end
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain: reset never clears it.
    always_ff @(posedge clk) begin
        if (commit && op == OP_WRITE && in_range)
            mem[word_addr] <= wdata;
    end

endmodule

// File: tb/tb_data_memory_hs.sv
module tb_data_memory_hs;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 10;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        icode;
    logic [DATA_W-1:0] valA, valE, valP;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] valM;
    logic              mem_error;
    logic [DATA_W-1:0] ram_val;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] mem_m [DEPTH];

    data_memory_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .valM       (valM),
        .mem_error  (mem_error),
        .ram_val    (ram_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1 && req_valid === 1'b1) begin
            assert (!$isunknown(icode)) else begin
                miscompares++;
                $error("FAIL icode_known: observed %h required no X", icode);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: which icodes touch memory, where, and with what data.
    task automatic model(input logic [3:0] ic, input logic [63:0] a, e, p,
                         output logic [63:0] x_valM, output logic x_err,
                         output logic [63:0] x_ram);
        bit rd, wr;
        logic [63:0] ad, dt;
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        ad = (ic == 4'h9 || ic == 4'hB) ? a : e;
        dt = (ic == 4'h8) ? p : a;
        x_valM = 0; x_err = 0; x_ram = 0;
        if (rd || wr) begin
            if (ad >= 64'(DEPTH)) x_err = 1;
            else if (rd) begin
                x_valM = mem_m[ad];
                x_ram  = mem_m[ad];
            end else begin
                mem_m[ad] = dt;
                x_ram     = dt;
            end
        end
    endtask

    task automatic wait_resp(output int cycles);
        cycles = 0;
        while (resp_valid !== 1'b1 && cycles < 40) begin
            check("req_ready_busy", 64'(req_ready), 64'd0);
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    // Called just after a negedge with the DUT idle.
    task automatic txn(input logic [3:0] ic, input logic [63:0] a, e, p, input int hold);
        logic [63:0] x_valM, x_ram, held;
        logic        x_err;
        int          cycles;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1; icode = ic; valA = a; valE = e; valP = p;
        @(posedge clk);
        model(ic, a, e, p, x_valM, x_err, x_ram);
        @(negedge clk);
        req_valid = 0;
        wait_resp(cycles);
        check("latency", 64'(cycles), 64'(LATENCY));
        check("valM", valM, x_valM);
        check("mem_error", 64'(mem_error), 64'(x_err));
        check("ram_val", ram_val, x_ram);
        held = valM;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                req_valid = 1; icode = 4'h4; valE = 64'd2; valA = 64'hDEAD;
            end
            @(posedge clk);
            @(negedge clk);
            req_valid = 0;
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_valM", valM, held);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 0;
        check("resp_valid_drop", 64'(resp_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int cycles;
        logic [3:0] ics [12];
        logic [63:0] ra, re;
        logic [63:0] dv, de, dr;
        logic        dx;
        ics = '{4'h5, 4'h4, 4'h8, 4'hA, 4'h9, 4'hB, 4'h0, 4'h1, 4'h6, 4'hF, 4'h5, 4'h4};
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;

        rst_n = 0; req_valid = 0; resp_ready = 0;
        icode = 0; valA = 0; valE = 0; valP = 0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_valM", valM, 64'd0);
        check("rst_mem_error", 64'(mem_error), 64'd0);
        check("rst_ram_val", ram_val, 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // write then read
        txn(4'h4, 64'd5, 64'd7, 64'd0, 0);
        txn(4'h5, 64'd0, 64'd7, 64'd0, 0);
        // call/ret, pushq/popq
        txn(4'h8, 64'd0, 64'd100, 64'h2A, 0);
        txn(4'h9, 64'd100, 64'd0, 64'd0, 0);
        txn(4'hA, 64'd9, 64'd101, 64'd0, 0);
        txn(4'hB, 64'd101, 64'd0, 64'd0, 0);
        // no-op
        txn(4'h1, 64'd7, 64'd7, 64'd7, 0);
        // range
        txn(4'h5, 64'd0, 64'd1024, 64'd0, 0);
        txn(4'h5, 64'd0, 64'd1023, 64'd0, 0);
        txn(4'h4, 64'hAB, 64'h1_0000_0003, 64'd0, 0);
        txn(4'h5, 64'd0, 64'd3, 64'd0, 0);
        // backpressure with an ignored request pulse, then confirm it did not write
        txn(4'h5, 64'd0, 64'd7, 64'd0, 5);
        txn(4'h5, 64'd0, 64'd2, 64'd0, 0);

        // reset while BUSY: valM currently nonzero from this read
        txn(4'h5, 64'd0, 64'd7, 64'd0, 0);
        req_valid = 1; icode = 4'h4; valE = 64'd5; valA = 64'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("abort_req_ready", 64'(req_ready), 64'd1);
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_valM", valM, 64'd0);
        check("abort_ram_val", ram_val, 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        txn(4'h5, 64'd0, 64'd5, 64'd0, 0);

        // reset while RESP: the write has already committed
        req_valid = 1; icode = 4'h4; valE = 64'd6; valA = 64'h66;
        @(posedge clk);
        model(4'h4, 64'h66, 64'd6, 64'd0, dv, dx, dr);
        @(negedge clk);
        req_valid = 0;
        wait_resp(cycles);
        check("resp_reset_latency", 64'(cycles), 64'(LATENCY));
        rst_n = 0;
        #1;
        check("resp_reset_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        txn(4'h5, 64'd0, 64'd6, 64'd0, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            ra = 64'($urandom_range(0, 15));
            re = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) re = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 9) == 0) ra = 64'($urandom_range(1020, 1030));
            txn(ics[$urandom_range(0, 11)],
                ($urandom_range(0, 1) == 1) ? ra : {32'($urandom), 32'($urandom)},
                re, {32'($urandom), 32'($urandom)}, int'($urandom_range(0, 2)));
        end
        // sweep the small address window to catch any stray writes
        for (int k = 0; k < 16; k++) txn(4'h5, 64'd0, 64'(k), 64'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
